// File: rtl/mul_div_pkg.sv
//==============================================================================
// mul_div_pkg : operation codes and FSM encoding for the iterative HI/LO unit
// Revision    : 1.0
//==============================================================================
`default_nettype none

package mul_div_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Low op bit clear means a two's-complement operation (MULT, DIV).
    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/abs_conv.sv
//==============================================================================
// abs_conv : magnitude and sign extraction of an optionally signed value
// Revision : 1.0
//==============================================================================
`default_nettype none

module abs_conv
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             is_signed,
    output logic [WIDTH-1:0] mag,
    output logic             neg
);

    // The most-negative input maps to 2**(WIDTH-1), which is exact as unsigned.
    always_comb begin
        neg = is_signed & value[WIDTH-1];
        mag = neg ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;
    end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
//==============================================================================
// mul_div_unit : iterative shift-add multiplier / restoring divider, HI/LO regs
// Revision     : 1.0
//==============================================================================
`default_nettype none

module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_en,
    input  logic             wr_hi,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t               state_q,    state_d;
    logic [1:0]           op_q,       op_d;
    logic                 sign_a_q,   sign_a_d;
    logic                 sign_b_q,   sign_b_d;
    logic                 div_zero_q, div_zero_d;
    logic [WIDTH-1:0]     opnd_q,     opnd_d;
    logic [2*WIDTH-1:0]   acc_q,      acc_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [WIDTH-1:0]     hi_q,       hi_d;
    logic [WIDTH-1:0]     lo_q,       lo_d;
    logic                 done_q,     done_d;

    logic                 op_signed;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 a_neg;
    logic                 b_neg;

    assign op_signed = is_signed_op(op);

    abs_conv #(.WIDTH(WIDTH)) u_abs_a (
        .value     (a),
        .is_signed (op_signed),
        .mag       (a_mag),
        .neg       (a_neg)
    );

    abs_conv #(.WIDTH(WIDTH)) u_abs_b (
        .value     (b),
        .is_signed (op_signed),
        .mag       (b_mag),
        .neg       (b_neg)
    );

    // One iteration of each algorithm; acc holds {high, low} halves.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;
    logic [WIDTH+1:0]     div_trial;
    logic [2*WIDTH-1:0]   div_step;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};

        div_trial = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {2'b00, opnd_q};
        if (!div_trial[WIDTH+1]) begin
            div_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_step = {acc_q[2*WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction of the unsigned result.
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     rem;
    logic [2*WIDTH-1:0]   prod_fixed;
    logic [WIDTH-1:0]     res_hi;
    logic [WIDTH-1:0]     res_lo;

    always_comb begin
        quot       = acc_q[WIDTH-1:0];
        rem        = acc_q[2*WIDTH-1:WIDTH];
        prod_fixed = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        res_hi     = prod_fixed[2*WIDTH-1:WIDTH];
        res_lo     = prod_fixed[WIDTH-1:0];
        if (is_div_op(op_q)) begin
            if (div_zero_q) begin
                // Remainder is |a| here; restoring the sign of a yields a itself.
                res_lo = {WIDTH{1'b1}};
                res_hi = sign_a_q ? -rem : rem;
            end else begin
                res_lo = (sign_a_q ^ sign_b_q) ? -quot : quot;
                res_hi = sign_a_q ? -rem : rem;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        div_zero_d = div_zero_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr_en) begin
                    if (wr_hi) begin
                        hi_d = wr_data;
                    end else begin
                        lo_d = wr_data;
                    end
                end
                if (start) begin
                    state_d    = ST_RUN;
                    op_d       = op;
                    sign_a_d   = a_neg;
                    sign_b_d   = b_neg;
                    div_zero_d = is_div_op(op) && (b == {WIDTH{1'b0}});
                    opnd_d     = b_mag;
                    acc_d      = {{WIDTH{1'b0}}, a_mag};
                    cnt_d      = CNT_W'(WIDTH);
                end
            end
            ST_RUN: begin
                acc_d = is_div_op(op_q) ? div_step : mul_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            op_q       <= 2'b00;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            div_zero_q <= 1'b0;
            opnd_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            div_zero_q <= div_zero_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    // done is registered out of DONE so it coincides with the return to IDLE.
    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
//==============================================================================
// tb_mul_div_unit : randomized self-checking bench for mul_div_unit (WIDTH=32)
// Revision        : 1.0
//==============================================================================
`default_nettype none

module tb_mul_div_unit;

    localparam int W         = 32;
    localparam int LATENCY   = W + 2;
    localparam int LAT_LIMIT = 200;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          wr_en;
    logic          wr_hi;
    logic [W-1:0]  wr_data;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int tests_run    = 0;
    int tests_failed = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .wr_en   (wr_en),
        .wr_hi   (wr_hi),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    // Architectural result {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint      sx, sy, sq, sr;
        logic [63:0] ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            2'b00: begin
                sq = sx * sy;
                p  = sq;
            end
            2'b01: p = ux * uy;
            2'b10: begin
                if (y == 32'd0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    p = {32'd0, 32'h8000_0000};
                end else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    p  = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (y == 32'd0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else begin
                    p = {x % y, x / y};
                end
            end
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Drives one start pulse and returns edges until done (or -1 on timeout).
    task automatic issue_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                            output int lat);
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom_range(0, 3));
        lat   = -1;
        for (int k = 1; k <= LAT_LIMIT; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        a       = '0;
        b       = '0;
        wr_en   = 1'b0;
        wr_hi   = 1'b0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
        tests_run++;
        if (hi !== 32'd0) begin tests_failed++; $display("FAIL reset_hi: got %h expected 0", hi); end
        tests_run++;
        if (lo !== 32'd0) begin tests_failed++; $display("FAIL reset_lo: got %h expected 0", lo); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    task automatic test_vectors();
        vec_t vecs[7];
        int   lat;
        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{2'b11, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF};
        vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[6] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        for (int i = 0; i < 7; i++) begin
            issue_op(vecs[i].o, vecs[i].x, vecs[i].y, lat);
            tests_run++;
            if (lat != LATENCY) begin
                tests_failed++;
                $display("FAIL vec%0d_latency: got %0d expected %0d", i, lat, LATENCY);
            end
            tests_run++;
            if (busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL vec%0d_busy_at_done: got %b expected 0", i, busy);
            end
            tests_run++;
            if (hi !== vecs[i].ehi || lo !== vecs[i].elo) begin
                tests_failed++;
                $display("FAIL vec%0d_result: got hi=%h lo=%h expected hi=%h lo=%h",
                         i, hi, lo, vecs[i].ehi, vecs[i].elo);
            end
        end
    endtask

    task automatic test_random();
        int          lat;
        logic [1:0]  o;
        logic [31:0] x, y;
        logic [63:0] exp;
        for (int i = 0; i < 40; i++) begin
            o   = 2'($urandom_range(0, 3));
            x   = pick_operand();
            y   = pick_operand();
            exp = ref_result(o, x, y);
            issue_op(o, x, y, lat);
            tests_run++;
            if (lat != LATENCY) begin
                tests_failed++;
                $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, LATENCY);
            end
            tests_run++;
            if ({hi, lo} !== exp) begin
                tests_failed++;
                $display("FAIL rand%0d_result op=%0d a=%h b=%h: got hi=%h lo=%h expected hi=%h lo=%h",
                         i, o, x, y, hi, lo, exp[63:32], exp[31:0]);
            end
            @(posedge clk);
            #1;
            tests_run++;
            if (done !== 1'b0) begin
                tests_failed++;
                $display("FAIL rand%0d_done_width: got %b expected 0", i, done);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] x0, y0, x1, y1;
        logic [63:0] exp;
        x0 = $urandom; y0 = $urandom; x1 = $urandom; y1 = $urandom_range(1, 1000);
        issue_op(2'b00, x0, y0, lat);
        exp = ref_result(2'b00, x0, y0);
        tests_run++;
        if (lat != LATENCY || {hi, lo} !== exp) begin
            tests_failed++;
            $display("FAIL b2b_first: got lat=%0d hi=%h lo=%h expected lat=%0d hi=%h lo=%h",
                     lat, hi, lo, LATENCY, exp[63:32], exp[31:0]);
        end
        issue_op(2'b10, x1, y1, lat);
        exp = ref_result(2'b10, x1, y1);
        tests_run++;
        if (lat != LATENCY || {hi, lo} !== exp) begin
            tests_failed++;
            $display("FAIL b2b_second: got lat=%0d hi=%h lo=%h expected lat=%0d hi=%h lo=%h",
                     lat, hi, lo, LATENCY, exp[63:32], exp[31:0]);
        end
    endtask

    task automatic test_direct_write();
        logic [31:0] v_hi, v_lo, old_lo, old_hi;
        v_hi   = $urandom;
        v_lo   = $urandom;
        old_lo = lo;
        @(negedge clk);
        wr_en = 1'b1; wr_hi = 1'b1; wr_data = v_hi;
        @(negedge clk);
        wr_en = 1'b0;
        tests_run++;
        if (hi !== v_hi) begin tests_failed++; $display("FAIL wr_hi_value: got %h expected %h", hi, v_hi); end
        tests_run++;
        if (lo !== old_lo) begin tests_failed++; $display("FAIL wr_hi_lo_kept: got %h expected %h", lo, old_lo); end
        old_hi = hi;
        wr_en = 1'b1; wr_hi = 1'b0; wr_data = v_lo;
        @(negedge clk);
        wr_en = 1'b0;
        tests_run++;
        if (lo !== v_lo) begin tests_failed++; $display("FAIL wr_lo_value: got %h expected %h", lo, v_lo); end
        tests_run++;
        if (hi !== old_hi) begin tests_failed++; $display("FAIL wr_lo_hi_kept: got %h expected %h", hi, old_hi); end
    endtask

    task automatic test_busy_ignore();
        int          first_done;
        int          n_done;
        logic [31:0] hi_before;
        hi_before  = hi;
        first_done = -1;
        n_done     = 0;
        @(negedge clk);
        op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = k;
                tests_run++;
                if (hi !== 32'd0 || lo !== 32'd6) begin
                    tests_failed++;
                    $display("FAIL busy_ignore_result: got hi=%h lo=%h expected hi=0 lo=6", hi, lo);
                end
            end
            if (k == 5) begin
                start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
                wr_en = 1'b1; wr_hi = 1'b1; wr_data = 32'h1234;
            end
            if (k == 6) begin
                start = 1'b0; wr_en = 1'b0;
                tests_run++;
                if (hi !== hi_before) begin
                    tests_failed++;
                    $display("FAIL busy_ignore_write: got hi=%h expected %h", hi, hi_before);
                end
            end
        end
        tests_run++;
        if (n_done != 1 || first_done != LATENCY) begin
            tests_failed++;
            $display("FAIL busy_ignore_pulses: got %0d pulses first at %0d expected 1 at %0d",
                     n_done, first_done, LATENCY);
        end
    endtask

    task automatic test_write_and_start();
        logic [31:0] v, x, y;
        logic [63:0] exp;
        int          lat;
        v = $urandom; x = $urandom; y = $urandom;
        exp = ref_result(2'b00, x, y);
        @(negedge clk);
        wr_en = 1'b1; wr_hi = 1'b0; wr_data = v;
        op = 2'b00; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0; start = 1'b0;
        tests_run++;
        if (lo !== v || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL wr_start_write: got lo=%h busy=%b expected lo=%h busy=1", lo, busy, v);
        end
        lat = -1;
        for (int k = 1; k <= LAT_LIMIT; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin lat = k; break; end
        end
        tests_run++;
        if (lat != LATENCY || {hi, lo} !== exp) begin
            tests_failed++;
            $display("FAIL wr_start_result: got lat=%0d hi=%h lo=%h expected lat=%0d hi=%h lo=%h",
                     lat, hi, lo, LATENCY, exp[63:32], exp[31:0]);
        end
    endtask

    task automatic test_reset_abort();
        int n_done;
        int lat;
        @(negedge clk);
        wr_en = 1'b1; wr_hi = 1'b1; wr_data = 32'hAAAA_5555;
        @(negedge clk);
        wr_hi = 1'b0; wr_data = 32'h0F0F_0F0F;
        @(negedge clk);
        wr_en = 1'b0;
        tests_run++;
        if (hi !== 32'hAAAA_5555 || lo !== 32'h0F0F_0F0F) begin
            tests_failed++;
            $display("FAIL abort_preload: got hi=%h lo=%h expected hi=aaaa5555 lo=0f0f0f0f", hi, lo);
        end
        op = 2'b10; a = $urandom; b = $urandom_range(1, 50); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_state: got hi=%h lo=%h busy=%b done=%b expected all zero",
                     hi, lo, busy, done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) n_done++;
        end
        tests_run++;
        if (n_done != 0 || hi !== 32'd0 || lo !== 32'd0) begin
            tests_failed++;
            $display("FAIL abort_no_done: got %0d pulses hi=%h lo=%h expected 0 pulses hi=0 lo=0",
                     n_done, hi, lo);
        end
        issue_op(2'b01, 32'd4, 32'd4, lat);
        tests_run++;
        if (lat != LATENCY || hi !== 32'd0 || lo !== 32'd16) begin
            tests_failed++;
            $display("FAIL abort_recover: got lat=%0d hi=%h lo=%h expected lat=%0d hi=0 lo=10",
                     lat, hi, lo, LATENCY);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_direct_write();
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_write_and_start();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting operand, HI and LO width; legal range is 8 to 64, even values only.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: rs and rt operands; a is the dividend and b the divisor for DIV/DIVU.
REQ-007 The block SHALL have port wr_en, input, 1 bit: direct HI/LO write (mthi/mtlo).
REQ-008 The block SHALL have port wr_hi, input, 1 bit: 1 selects HI, 0 selects LO for the direct write.
REQ-009 The block SHALL have port wr_data, input, WIDTH bits: direct write value.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-012 The block SHALL have ports hi and lo, output, WIDTH bits each: architectural HI/LO registers.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, RUN, FIX and DONE.
REQ-014 IDLE SHALL go to RUN when start=1: latch op, latch sign flags, and latch magnitudes of a and b (raw values for MULTU/DIVU).
REQ-015 RUN SHALL last exactly WIDTH cycles, counted by a down-counter.
REQ-016 Each RUN cycle of a multiply SHALL do one shift-add step: conditional add of the multiplicand, then shift right of the 2*WIDTH accumulator.
REQ-017 Each RUN cycle of a divide SHALL do one restoring step: shift the remainder/quotient pair left, trial-subtract the divisor, keep the result if non-negative and set the quotient bit.
REQ-018 FIX SHALL apply signs in one cycle:
- MULT: negate the 2*WIDTH product if sign(a) differs from sign(b).
- DIV: negate the quotient if signs differ; give the remainder the sign of a.
REQ-019 On entry to DONE, HI/LO SHALL be written: multiply gives {hi,lo} = product; divide gives lo = quotient, hi = remainder.
REQ-020 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-021 Latency: done SHALL be high in the cycle starting WIDTH+2 rising edges after the edge that sampled start; busy SHALL fall in that same cycle.
REQ-022 Divide by zero (b=0, DIV or DIVU) SHALL still take full latency and SHALL bypass FIX, giving lo = all ones and hi = a unmodified.
REQ-023 Signed overflow case DIV with a=most-negative and b=-1 SHALL give lo = most-negative and hi = 0.
REQ-024 MULT with both operands most-negative SHALL give the exact 2*WIDTH product.
REQ-025 start while busy=1 SHALL be ignored; a and b need not be held after the sampling edge.
REQ-026 wr_en in IDLE SHALL write wr_data to the selected register at the next edge, with the other register unchanged.
REQ-027 wr_en while busy SHALL be ignored.
REQ-028 If wr_en and start are both high in IDLE, the write SHALL take effect and the operation SHALL start; the operation result later overwrites both registers.
REQ-029 hi and lo SHALL hold their value at all times other than DONE entry or an accepted direct write.

Reset
REQ-030 reset=0 SHALL asynchronously force: state IDLE, busy 0, done 0, hi 0, lo 0, counter 0, and all internal accumulators 0.
REQ-031 Reset during RUN or FIX SHALL abort the operation with no HI/LO update.
REQ-032 Reset SHALL be released synchronously to clk by the environment.

Structure
REQ-033 A shared package mul_div_pkg SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the FSM state encoding.
REQ-034 One sub-module abs_conv SHALL be instantiated: it takes a value and a signed flag and returns the magnitude plus a sign bit.
REQ-035 No combinational multiplier or divider SHALL be inferred.

Verification (WIDTH=32)
REQ-036 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done 34 edges after start.
REQ-037 MULT a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-038 DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=0x00000005.
REQ-039 Start MULTU 2*3, then pulse start and wr_en (HI=0x1234) at cycle 5 -> both ignored; result hi=0, lo=6; one done pulse only.
REQ-040 Assert reset at cycle 10 of a DIV whose HI/LO were preloaded via wr_en -> hi=lo=0, busy=0, no done; a new MULTU 4*4 afterwards gives lo=16.
